// File: rtl/arp_rx_parser.sv
// ARP receive parser: checks the Ethernet/ARP header of each received frame
// and hands the sender IP/MAC pair of every valid frame addressed to this node
// to the ARP cache.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   rx_sof/rx_valid/rx_data  MAC receive byte stream (sof qualified by valid)
//   rx_eof/rx_err            end of frame, MAC error flag sampled with eof
//   arp_found                one-cycle pulse, valid ARP frame accepted
//   arp_rec_source_ip_addr   SPA of the last accepted frame
//   arp_rec_source_mac_addr  SHA of the last accepted frame
//   arp_req_rcvd/rep_rcvd    opcode pulses, coincident with arp_found
module arp_rx_parser #(
    parameter logic [47:0] LOCAL_MAC = 48'h00_0a_35_01_fe_c0,
    parameter logic [31:0] LOCAL_IP  = 32'hc0_a8_01_0b
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_sof,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_eof,
    input  logic        rx_err,
    output logic        arp_found,
    output logic [31:0] arp_rec_source_ip_addr,
    output logic [47:0] arp_rec_source_mac_addr,
    output logic        arp_req_rcvd,
    output logic        arp_rep_rcvd
);
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned CNT_MAX = 63;
    localparam int unsigned MIN_LEN = 42;

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP, S_CHECK} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_da_bc, r_da_lm, r_oper_req;
    logic [47:0]        r_sha;
    logic [31:0]        r_spa;
    logic               r_found, r_req, r_rep;
    logic [31:0]        r_ip;
    logic [47:0]        r_mac;

    logic               w_start, w_eval, w_accept, w_byte_ok, w_bc_ok, w_lm_ok;
    logic [CNT_W-1:0]   w_idx, w_cnt_inc, w_len;
    logic [7:0]         w_mac_byte;

    // Byte index, per-byte header check and next-state decision
    always_comb begin
        w_start     = rx_valid & rx_sof;
        w_idx       = w_start ? '0 : r_cnt;
        w_cnt_inc   = (w_idx == CNT_W'(CNT_MAX)) ? w_idx : w_idx + CNT_W'(1);
        w_len       = rx_valid ? w_cnt_inc : w_idx;
        w_mac_byte  = 8'h00;
        w_byte_ok   = 1'b1;
        w_state_nxt = r_state;
        w_eval      = 1'b0;
        w_accept    = 1'b0;

        case (w_idx)
            6'd0:    w_mac_byte = LOCAL_MAC[47:40];
            6'd1:    w_mac_byte = LOCAL_MAC[39:32];
            6'd2:    w_mac_byte = LOCAL_MAC[31:24];
            6'd3:    w_mac_byte = LOCAL_MAC[23:16];
            6'd4:    w_mac_byte = LOCAL_MAC[15:8];
            6'd5:    w_mac_byte = LOCAL_MAC[7:0];
            default: w_mac_byte = 8'h00;
        endcase

        // DA tracks broadcast and unicast candidates in parallel
        w_bc_ok = (rx_data == 8'hff)       && ((w_idx == '0) || r_da_bc);
        w_lm_ok = (rx_data == w_mac_byte)  && ((w_idx == '0) || r_da_lm);

        case (w_idx)
            6'd0, 6'd1, 6'd2,
            6'd3, 6'd4, 6'd5: w_byte_ok = w_bc_ok | w_lm_ok;
            6'd12:   w_byte_ok = (rx_data == 8'h08);
            6'd13:   w_byte_ok = (rx_data == 8'h06);
            6'd14:   w_byte_ok = (rx_data == 8'h00);
            6'd15:   w_byte_ok = (rx_data == 8'h01);
            6'd16:   w_byte_ok = (rx_data == 8'h08);
            6'd17:   w_byte_ok = (rx_data == 8'h00);
            6'd18:   w_byte_ok = (rx_data == 8'h06);
            6'd19:   w_byte_ok = (rx_data == 8'h04);
            6'd20:   w_byte_ok = (rx_data == 8'h00);
            6'd21:   w_byte_ok = (rx_data == 8'h01) || (rx_data == 8'h02);
            6'd38:   w_byte_ok = (rx_data == LOCAL_IP[31:24]);
            6'd39:   w_byte_ok = (rx_data == LOCAL_IP[23:16]);
            6'd40:   w_byte_ok = (rx_data == LOCAL_IP[15:8]);
            6'd41:   w_byte_ok = (rx_data == LOCAL_IP[7:0]);
            default: w_byte_ok = 1'b1;
        endcase

        case (r_state)
            S_IDLE:  w_eval = w_start;
            S_RECV:  w_eval = 1'b1;
            S_DROP: begin
                w_eval = w_start;
                if (rx_eof) w_state_nxt = S_IDLE;
            end
            S_CHECK: begin
                w_eval      = w_start;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // The current byte is checked before any eof decision is taken
        if (w_eval) begin
            if (rx_valid && !w_byte_ok) begin
                w_state_nxt = rx_eof ? S_IDLE : S_DROP;
            end else if (rx_eof) begin
                if (w_len >= CNT_W'(MIN_LEN)) begin
                    w_state_nxt = S_CHECK;
                    w_accept    = ~rx_err;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end else begin
                w_state_nxt = S_RECV;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Byte counter and shadow capture of header fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_da_bc    <= 1'b0;
            r_da_lm    <= 1'b0;
            r_oper_req <= 1'b0;
            r_sha      <= '0;
            r_spa      <= '0;
        end else begin
            if (w_state_nxt != S_RECV)       r_cnt <= '0;
            else if (w_eval && rx_valid)     r_cnt <= w_cnt_inc;

            if (w_eval && rx_valid) begin
                if (w_idx < CNT_W'(6)) begin
                    r_da_bc <= w_bc_ok;
                    r_da_lm <= w_lm_ok;
                end
                if (w_idx == CNT_W'(21))
                    r_oper_req <= (rx_data == 8'h01);
                if (w_idx >= CNT_W'(22) && w_idx < CNT_W'(28))
                    r_sha <= {r_sha[39:0], rx_data};
                if (w_idx >= CNT_W'(28) && w_idx < CNT_W'(32))
                    r_spa <= {r_spa[23:0], rx_data};
            end
        end
    end

    // Result pulses; the address outputs change only for accepted frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_found <= 1'b0;
            r_req   <= 1'b0;
            r_rep   <= 1'b0;
            r_ip    <= '0;
            r_mac   <= '1;
        end else begin
            r_found <= w_accept;
            r_req   <= w_accept &  r_oper_req;
            r_rep   <= w_accept & ~r_oper_req;
            if (w_accept) begin
                r_ip  <= r_spa;
                r_mac <= r_sha;
            end
        end
    end

    assign arp_found               = r_found;
    assign arp_req_rcvd            = r_req;
    assign arp_rep_rcvd            = r_rep;
    assign arp_rec_source_ip_addr  = r_ip;
    assign arp_rec_source_mac_addr = r_mac;

endmodule

// File: tb/tb_arp_rx_parser.sv
// Bench for arp_rx_parser: table of directed frames, hand-written corner
// sequences and randomized frames, all checked each cycle against a
// frame-level reference model.
module tb_arp_rx_parser;
    localparam logic [47:0] LOCAL_MAC = 48'h00_0a_35_01_fe_c0;
    localparam logic [31:0] LOCAL_IP  = 32'hc0_a8_01_0b;
    localparam logic [31:0] TPA_OK    = 32'hc0a8010b;
    localparam logic [15:0] ETH_ARP   = 16'h0806;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rx_sof = 1'b0, rx_valid = 1'b0, rx_eof = 1'b0, rx_err = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        arp_found, arp_req_rcvd, arp_rep_rcvd;
    logic [31:0] arp_rec_source_ip_addr;
    logic [47:0] arp_rec_source_mac_addr;

    arp_rx_parser dut (
        .clk(clk), .rst_n(rst_n), .rx_sof(rx_sof), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_eof(rx_eof), .rx_err(rx_err),
        .arp_found(arp_found),
        .arp_rec_source_ip_addr(arp_rec_source_ip_addr),
        .arp_rec_source_mac_addr(arp_rec_source_mac_addr),
        .arp_req_rcvd(arp_req_rcvd), .arp_rep_rcvd(arp_rep_rcvd)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pulses = 0, reqs = 0, reps = 0;

    // Reference model: bytes of the open frame, judged as a whole at eof
    logic [7:0]  mq[$];
    logic [7:0]  fq[$];
    bit          in_frame = 1'b0;
    logic        m_found = 1'b0, m_req = 1'b0, m_rep = 1'b0;
    logic [31:0] m_ip = '0;
    logic [47:0] m_mac = '1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] field(input int off, input int n);
        logic [47:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[39:0], mq[off+i]};
        return v;
    endfunction

    function automatic bit frame_ok();
        logic [47:0] oper;
        if (mq.size() < 42) return 1'b0;
        if (field(0, 6) != 48'hffff_ffff_ffff && field(0, 6) != LOCAL_MAC) return 1'b0;
        if (field(12, 2) != 48'h0806) return 1'b0;
        if (field(14, 2) != 48'h0001) return 1'b0;
        if (field(16, 2) != 48'h0800) return 1'b0;
        if (field(18, 2) != 48'h0604) return 1'b0;
        oper = field(20, 2);
        if (oper != 48'd1 && oper != 48'd2) return 1'b0;
        if (field(38, 4) != {16'h0, LOCAL_IP}) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clock(input logic sof, input logic valid, input logic [7:0] d,
                               input logic eof, input logic err);
        m_found = 1'b0; m_req = 1'b0; m_rep = 1'b0;
        if (valid && sof) begin
            mq.delete();
            in_frame = 1'b1;
        end
        if (valid && in_frame) mq.push_back(d);
        if (eof && in_frame) begin
            in_frame = 1'b0;
            if (!err && frame_ok()) begin
                m_found = 1'b1;
                m_req   = (field(20, 2) == 48'd1);
                m_rep   = (field(20, 2) == 48'd2);
                m_ip    = field(28, 4)[31:0];
                m_mac   = field(22, 6);
            end
        end
    endtask

    // One clock: drive on the falling edge, compare just after the rising edge
    task automatic step(input logic sof, input logic valid, input logic [7:0] d,
                        input logic eof, input logic err);
        @(negedge clk);
        rx_sof = sof; rx_valid = valid; rx_data = d; rx_eof = eof; rx_err = err;
        @(posedge clk);
        model_clock(sof, valid, d, eof, err);
        #1;
        chk("pulses", {61'b0, arp_found, arp_req_rcvd, arp_rep_rcvd}, {61'b0, m_found, m_req, m_rep});
        chk("ip", {32'b0, arp_rec_source_ip_addr}, {32'b0, m_ip});
        chk("mac", {16'b0, arp_rec_source_mac_addr}, {16'b0, m_mac});
        if (arp_found === 1'b1) begin
            pulses++;
            if (arp_req_rcvd === 1'b1) reqs++;
            if (arp_rep_rcvd === 1'b1) reps++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx_sof = 1'b0; rx_valid = 1'b0; rx_eof = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
        #1;
        mq.delete(); in_frame = 1'b0;
        m_found = 1'b0; m_req = 1'b0; m_rep = 1'b0; m_ip = '0; m_mac = '1;
        chk("rst_pulses", {61'b0, arp_found, arp_req_rcvd, arp_rep_rcvd}, 64'd0);
        chk("rst_ip", {32'b0, arp_rec_source_ip_addr}, 64'd0);
        chk("rst_mac", {16'b0, arp_rec_source_mac_addr}, {16'b0, 48'hffff_ffff_ffff});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic build_frame(input int da_mode, input logic [15:0] etype, input logic [15:0] oper,
                               input logic [47:0] sha, input logic [31:0] spa,
                               input logic [31:0] tpa, input int len);
        logic [47:0]  da;
        logic [335:0] h;
        da = (da_mode == 0) ? 48'hffff_ffff_ffff : (da_mode == 1) ? LOCAL_MAC : 48'h000a_3501_fec1;
        h = {da, 48'h0200_0000_0001, etype, 16'h0001, 16'h0800, 8'h06, 8'h04,
             oper, sha, spa, 48'h0, tpa};
        fq.delete();
        for (int i = 0; i < len; i++) fq.push_back((i < 42) ? h[335 - 8*i -: 8] : 8'h00);
    endtask

    // gap_mode 0: none, 1: 3 idle cycles before bytes 10/25/40, 2: random
    task automatic send_frame(input int gap_mode, input bit eof_same, input logic err, input int stop_at);
        int n;
        n = fq.size();
        for (int i = 0; i < n; i++) begin
            if (i == stop_at) return;
            if (gap_mode == 1 && (i == 10 || i == 25 || i == 40))
                repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            if (gap_mode == 2 && i > 0 && $urandom_range(0, 7) == 0)
                repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0);
            if (eof_same && i == n - 1) step(i == 0, 1'b1, fq[i], 1'b1, err);
            else                        step(i == 0, 1'b1, fq[i], 1'b0, 1'b0);
        end
        if (!eof_same) step(1'b0, 1'b0, 8'h00, 1'b1, err);
    endtask

    typedef struct {
        int          da_mode;
        logic [15:0] etype;
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [31:0] tpa;
        int          len;
        bit          eof_same;
        bit          err;
        bit          exp_found;
        bit          exp_req;
        bit          exp_rep;
    } vec_t;

    vec_t        tbl[11];
    logic [31:0] exp_ip;
    logic [47:0] exp_mac;
    int          p0, q0, r0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{0, ETH_ARP,  16'd1, 48'h112233445566, 32'hc0a80102, TPA_OK,       60, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1, ETH_ARP,  16'd2, 48'haabbccddeeff, 32'hc0a80105, TPA_OK,       60, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{0, ETH_ARP,  16'd1, 48'h0a0b0c0d0e0f, 32'hc0a80106, 32'hc0a80109, 60, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{0, 16'h0800, 16'd1, 48'h0a0b0c0d0e0f, 32'hc0a80107, TPA_OK,       60, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{0, ETH_ARP,  16'd3, 48'h0a0b0c0d0e0f, 32'hc0a80107, TPA_OK,       60, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{0, ETH_ARP,  16'd1, 48'h0a0b0c0d0e0f, 32'hc0a80107, TPA_OK,       60, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{0, ETH_ARP,  16'd1, 48'h0a0b0c0d0e0f, 32'hc0a80107, TPA_OK,       40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{0, ETH_ARP,  16'd2, 48'h665544332211, 32'hc0a80108, TPA_OK,       42, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1, ETH_ARP,  16'd1, 48'h010203040506, 32'hc0a80109, TPA_OK,       70, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{2, ETH_ARP,  16'd1, 48'h0a0b0c0d0e0f, 32'hc0a80107, TPA_OK,       60, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{0, ETH_ARP,  16'd1, 48'h0a0b0c0d0e0f, 32'hc0a80107, TPA_OK,       41, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        do_reset();
        exp_ip = '0; exp_mac = '1;

        // Directed table
        for (int t = 0; t < 11; t++) begin
            p0 = pulses; q0 = reqs; r0 = reps;
            if (tbl[t].exp_found) begin
                exp_ip = tbl[t].spa; exp_mac = tbl[t].sha;
            end
            build_frame(tbl[t].da_mode, tbl[t].etype, tbl[t].oper, tbl[t].sha,
                        tbl[t].spa, tbl[t].tpa, tbl[t].len);
            send_frame(0, tbl[t].eof_same, tbl[t].err, -1);
            step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_found", t), 64'(pulses - p0), {63'b0, tbl[t].exp_found});
            chk($sformatf("tbl%0d_req", t), 64'(reqs - q0), {63'b0, tbl[t].exp_req});
            chk($sformatf("tbl%0d_rep", t), 64'(reps - r0), {63'b0, tbl[t].exp_rep});
            chk($sformatf("tbl%0d_ip", t), {32'b0, arp_rec_source_ip_addr}, {32'b0, exp_ip});
            chk($sformatf("tbl%0d_mac", t), {16'b0, arp_rec_source_mac_addr}, {16'b0, exp_mac});
        end

        // sof reasserted at byte 20, followed by a complete frame
        p0 = pulses;
        build_frame(0, ETH_ARP, 16'd1, 48'h0a0a0a0a0a0a, 32'hc0a80120, TPA_OK, 60);
        send_frame(0, 1'b1, 1'b0, 20);
        build_frame(0, ETH_ARP, 16'd1, 48'h0b0b0b0b0b0b, 32'hc0a80121, TPA_OK, 60);
        send_frame(0, 1'b1, 1'b0, -1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("abort_found", 64'(pulses - p0), 64'd1);
        chk("abort_ip", {32'b0, arp_rec_source_ip_addr}, 64'h0000_0000_c0a8_0121);

        // 3-cycle valid gaps at bytes 10, 25, 40; pulse right after the eof edge
        p0 = pulses;
        build_frame(0, ETH_ARP, 16'd1, 48'h0c0c0c0c0c0c, 32'hc0a80122, TPA_OK, 60);
        send_frame(1, 1'b1, 1'b0, -1);
        chk("gap_found_now", {63'b0, arp_found}, 64'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("gap_found_once", 64'(pulses - p0), 64'd1);
        chk("gap_ip", {32'b0, arp_rec_source_ip_addr}, 64'h0000_0000_c0a8_0122);

        // Reset at byte 30, then eof
        p0 = pulses;
        build_frame(0, ETH_ARP, 16'd1, 48'h0d0d0d0d0d0d, 32'hc0a80123, TPA_OK, 60);
        send_frame(0, 1'b1, 1'b0, 30);
        do_reset();
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rstmid_found", 64'(pulses - p0), 64'd0);
        chk("rstmid_ip", {32'b0, arp_rec_source_ip_addr}, 64'd0);
        chk("rstmid_mac", {16'b0, arp_rec_source_mac_addr}, {16'b0, 48'hffff_ffff_ffff});

        // Back-to-back frames with no idle cycle between them
        p0 = pulses;
        build_frame(0, ETH_ARP, 16'd1, 48'h0e0e0e0e0e0e, 32'hc0a80124, TPA_OK, 42);
        send_frame(0, 1'b1, 1'b0, -1);
        build_frame(1, ETH_ARP, 16'd2, 48'h0f0f0f0f0f0f, 32'hc0a80125, TPA_OK, 42);
        send_frame(0, 1'b1, 1'b0, -1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("b2b_found", 64'(pulses - p0), 64'd2);
        chk("b2b_ip", {32'b0, arp_rec_source_ip_addr}, 64'h0000_0000_c0a8_0125);

        // Randomized frames against the reference model
        for (int r = 0; r < 80; r++) begin
            int          da_mode, len, stop_at;
            logic [15:0] etype, oper;
            logic [31:0] tpa;
            da_mode = ($urandom_range(0, 5) == 0) ? 2 : int'($urandom_range(0, 1));
            etype   = ($urandom_range(0, 9) == 0) ? 16'h0800 : ETH_ARP;
            oper    = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 4)) : 16'($urandom_range(1, 2));
            tpa     = ($urandom_range(0, 7) == 0) ? $urandom : TPA_OK;
            len     = int'($urandom_range(38, 75));
            build_frame(da_mode, etype, oper, {$urandom, 16'($urandom)}, $urandom, tpa, len);
            if ($urandom_range(0, 3) == 0) begin
                int k;
                k = int'($urandom_range(0, 41));
                if (k < len) fq[k] = fq[k] ^ 8'($urandom_range(1, 255));
            end
            stop_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 50)) : -1;
            send_frame($urandom_range(0, 1) == 0 ? 0 : 2, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 7) == 0, stop_at);
            if (stop_at >= 0 && $urandom_range(0, 2) == 0) do_reset();
            repeat ($urandom_range(0, 3))
                step(1'b0, $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 5) == 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/arp_rx_parser.md
Name: arp_rx_parser

Overview:
- Receive-side ARP frame parser between the Ethernet MAC receive byte stream and the ARP cache.
- Takes frame bytes starting at the destination MAC (preamble/SFD already stripped, FCS already checked by the MAC).
- Validates the Ethernet/ARP header fields and target address.
- Emits a one-cycle arp_found pulse with the sender IP/MAC pair for the cache, plus request/reply indications for the ARP transmit side.

Parameters:
- LOCAL_MAC, 48'h00_0a_35_01_fe_c0, this node's MAC address.
- LOCAL_IP, 32'hc0_a8_01_0b, this node's IPv4 address (192.168.1.11).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- rx_sof  input  1  high with the first byte of a frame (destination MAC byte 0); qualified by rx_valid
- rx_valid  input  1  rx_data holds a valid frame byte this cycle
- rx_data  input  8  frame byte, network order, MSB-first fields
- rx_eof  input  1  frame ended this cycle; may coincide with the last rx_valid byte or follow it
- rx_err  input  1  MAC flagged FCS/length error; sampled together with rx_eof
- arp_found  output  1  one-cycle pulse: valid ARP frame accepted
- arp_rec_source_ip_addr  output  32  sender protocol address (SPA) of the last accepted frame
- arp_rec_source_mac_addr  output  48  sender hardware address (SHA) of the last accepted frame
- arp_req_rcvd  output  1  one-cycle pulse with arp_found when OPER = 1
- arp_rep_rcvd  output  1  one-cycle pulse with arp_found when OPER = 2

Behaviour:
- Reset values: all pulses 0; arp_rec_source_ip_addr = 0; arp_rec_source_mac_addr = 48'hff_ff_ff_ff_ff_ff; FSM in IDLE; byte counter 0.
- Byte counter: 6 bits, counts rx_valid bytes, saturates at 63. The byte carrying rx_sof is index 0.

Field checks (byte index: required value):
- 0-5 (DA): all bytes 8'hff, or equal to LOCAL_MAC.
- 12-13 (ethertype): 16'h0806.
- 14-15 (HTYPE): 16'h0001.
- 16-17 (PTYPE): 16'h0800.
- 18 (HLEN): 8'h06.
- 19 (PLEN): 8'h04.
- 20-21 (OPER): 1 or 2.
- 22-27: captured as SHA into a shadow register.
- 28-31: captured as SPA into a shadow register.
- 32-37 (THA): ignored.
- 38-41 (TPA): must equal LOCAL_IP.
- Bytes 42 and up (padding) are ignored.

FSM:
- IDLE: on rx_valid and rx_sof, load byte 0 and go to RECV. Bytes without sof are ignored.
- RECV: check each byte as it arrives.
  - Any mismatch -> DROP.
  - rx_eof before 42 bytes received -> IDLE, no output.
  - rx_eof with count >= 42 -> CHECK.
- DROP: ignore bytes until rx_eof, then go to IDLE. No output.
- CHECK (one cycle): if rx_err was low at eof, copy the shadow SHA/SPA to the outputs and pulse arp_found plus the matching opcode pulse. Always return to IDLE.

Timing:
- Latency: arp_found asserts exactly 1 cycle after the rx_eof cycle.
- Output address registers update in the same cycle arp_found rises and hold until the next accepted frame. Shadow registers never alter the outputs of a dropped frame.

Boundary rules:
- rx_sof in any non-IDLE state: abort the current frame, restart at index 0 with this byte, go to RECV.
- rx_eof in the same cycle as the final byte: that byte is counted and checked first, then the eof decision is made.
- Frames longer than 63 bytes: counter saturates and the frame is still accepted.
- rx_valid gaps inside a frame are permitted. The counter only advances on valid bytes.
- Reset mid-frame: return immediately to IDLE with reset values. The frame is lost, and no pulse is emitted after reset release.
- Back-to-back frames (sof in the cycle after CHECK): must be accepted.

Test Plan:
- Broadcast ARP request: DA ff..ff, OPER 1, SHA 11:22:33:44:55:66, SPA c0a80102, TPA c0a8010b, eof at byte 59 -> one cycle after eof: arp_found = 1 and arp_req_rcvd = 1 for one cycle; outputs = c0a80102 / 112233445566.
- Unicast ARP reply to LOCAL_MAC, OPER 2, SPA c0a80105 -> arp_rep_rcvd pulse; IP output updates to c0a80105.
- Negative cases: TPA c0a80109, ethertype 0800, OPER 3, rx_err = 1 at eof, or eof after 40 bytes -> no pulses; outputs keep their previous values.
- rx_sof reasserted at byte 20 of a valid frame, followed by a full valid frame -> exactly one arp_found, carrying the second frame's fields.
- rx_valid deasserted for 3 cycles at bytes 10, 25 and 40 of a valid request -> accepted normally, 1 cycle after eof.
- rst_n asserted low at byte 30 and released, then eof driven -> no arp_found; outputs at reset values (0 / ff..ff).
